// File: rtl/cu_pkg.sv
// Shared definitions for the single-bus CPU control unit: opcodes, sequencer
// states, instruction classes and fault codes.
`timescale 1ns/1ps
package cu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHL  = 5'b00101;
    localparam logic [4:0] OP_ROR  = 5'b00110;
    localparam logic [4:0] OP_ROL  = 5'b00111;
    localparam logic [4:0] OP_ADDI = 5'b01000;
    localparam logic [4:0] OP_ANDI = 5'b01001;
    localparam logic [4:0] OP_ORI  = 5'b01010;
    localparam logic [4:0] OP_LD   = 5'b01011;
    localparam logic [4:0] OP_ST   = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b01101;
    localparam logic [4:0] OP_JR   = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b10001;
    localparam logic [4:0] OP_MFLO = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b10100;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_IMM, CL_LD, CL_ST, CL_BR, CL_JR,
        CL_MULDIV, CL_MFHL, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_t;

    // Immediate forms reuse the ALU code of their register-register twin.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] opcode);
        case (opcode)
            OP_ADDI: return OP_ADD;
            OP_ANDI: return OP_AND;
            default: return OP_OR;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: IR/condition/memory-ready inputs and all
// strobes, ALU select and status outputs of the sequencer.
`timescale 1ns/1ps
interface cu_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_rdy;
    logic        pc_out, pc_in, inc_pc;
    logic        mar_in, mdr_in, mdr_out, mdr_read, mem_write;
    logic        ir_in, y_in, z_in, zlo_out, zhi_out, c_out, con_in;
    logic        gra, grb, grc, r_in, r_out, ba_out;
    logic        hi_in, lo_in, hi_out, lo_out;
    logic [4:0]  alu_op;
    logic        run, halted;
    logic [1:0]  fault;

    modport master (
        input  ir, con_ff, mem_rdy,
        output pc_out, pc_in, inc_pc,
        output mar_in, mdr_in, mdr_out, mdr_read, mem_write,
        output ir_in, y_in, z_in, zlo_out, zhi_out, c_out, con_in,
        output gra, grb, grc, r_in, r_out, ba_out,
        output hi_in, lo_in, hi_out, lo_out,
        output alu_op, run, halted, fault
    );

    modport slave (
        output ir, con_ff, mem_rdy,
        input  pc_out, pc_in, inc_pc,
        input  mar_in, mdr_in, mdr_out, mdr_read, mem_write,
        input  ir_in, y_in, z_in, zlo_out, zhi_out, c_out, con_in,
        input  gra, grb, grc, r_in, r_out, ba_out,
        input  hi_in, lo_in, hi_out, lo_out,
        input  alu_op, run, halted, fault
    );
endinterface

// File: rtl/instr_class_decode.sv
// Combinational opcode -> instruction class decode. MUL/DIV/MFHI/MFLO are only
// recognised when CU_MULDIV_EN is defined; otherwise they decode as illegal.
`timescale 1ns/1ps
module instr_class_decode
    import cu_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls
);

    always_comb begin
        cls = CL_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:       cls = CL_IMM;
            OP_LD:                          cls = CL_LD;
            OP_ST:                          cls = CL_ST;
            OP_BR:                          cls = CL_BR;
            OP_JR:                          cls = CL_JR;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:                 cls = CL_MULDIV;
            OP_MFHI, OP_MFLO:               cls = CL_MFHL;
`endif
            OP_NOP:                         cls = CL_NOP;
            OP_HALT:                        cls = CL_HALT;
            default:                        cls = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the single-bus CPU: fetch T0-T2, class-specific execute
// T3-T7, HALT with fault reporting. Optional HI/LO support via CU_MULDIV_EN.
`timescale 1ns/1ps
module control_unit
    import cu_pkg::*;
#(
    parameter int WAIT_LIMIT = 0
) (
    input  logic clk,
    input  logic clr,
    cu_if.master bus
);

    localparam logic [15:0] WAIT_LAST = (WAIT_LIMIT > 0) ? 16'(WAIT_LIMIT - 1) : 16'd0;

    state_t      state, state_n;
    logic [1:0]  fault_q, fault_n;
    logic [15:0] wait_cnt;
    iclass_t     cls;
    logic [4:0]  opcode;
    logic        in_wait, stalled, timeout;

    assign opcode = bus.ir[31:27];

    instr_class_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    // Memory wait states: fetch read, ld data read, st write.
    assign in_wait = (state == S_T1)
                  || (state == S_T6 && cls == CL_LD)
                  || (state == S_T7 && cls == CL_ST);
    assign stalled = in_wait && !bus.mem_rdy;
    assign timeout = stalled && (WAIT_LIMIT > 0) && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_RESET;
            fault_q  <= FAULT_NONE;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            fault_q  <= fault_n;
            wait_cnt <= stalled ? wait_cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        state_n = state;
        fault_n = fault_q;
        if (timeout) begin
            state_n = S_HALT;
            fault_n = FAULT_TIMEOUT;
        end else if (!stalled) begin
            case (state)
                S_RESET: state_n = S_T0;
                S_T0:    state_n = S_T1;
                S_T1:    state_n = S_T2;
                S_T2:    state_n = S_T3;
                S_T3: begin
                    case (cls)
                        CL_HALT:                  state_n = S_HALT;
                        CL_ILLEGAL: begin
                            state_n = S_HALT;
                            fault_n = FAULT_ILLEGAL;
                        end
                        CL_JR, CL_NOP, CL_MFHL:   state_n = S_T0;
                        default:                  state_n = S_T4;
                    endcase
                end
                S_T4:    state_n = S_T5;
                S_T5:    state_n = (cls == CL_RTYPE || cls == CL_IMM) ? S_T0 : S_T6;
                S_T6:    state_n = (cls == CL_LD || cls == CL_ST) ? S_T7 : S_T0;
                S_T7:    state_n = S_T0;
                S_HALT:  state_n = S_HALT;
                default: state_n = S_RESET;
            endcase
        end
    end

    always_comb begin
        bus.pc_out = 1'b0;  bus.pc_in = 1'b0;   bus.inc_pc = 1'b0;
        bus.mar_in = 1'b0;  bus.mdr_in = 1'b0;  bus.mdr_out = 1'b0;
        bus.mdr_read = 1'b0; bus.mem_write = 1'b0;
        bus.ir_in = 1'b0;   bus.y_in = 1'b0;    bus.z_in = 1'b0;
        bus.zlo_out = 1'b0; bus.zhi_out = 1'b0; bus.c_out = 1'b0;
        bus.con_in = 1'b0;
        bus.gra = 1'b0;     bus.grb = 1'b0;     bus.grc = 1'b0;
        bus.r_in = 1'b0;    bus.r_out = 1'b0;   bus.ba_out = 1'b0;
        bus.hi_in = 1'b0;   bus.lo_in = 1'b0;   bus.hi_out = 1'b0;
        bus.lo_out = 1'b0;
        bus.alu_op = 5'b00000;
        bus.run    = (state != S_RESET) && (state != S_HALT);
        bus.halted = (state == S_HALT);
        bus.fault  = fault_q;
        case (state)
            S_T0: begin bus.pc_out = 1'b1; bus.mar_in = 1'b1; bus.inc_pc = 1'b1; end
            S_T1: begin bus.mdr_read = 1'b1; bus.mdr_in = 1'b1; end
            S_T2: begin bus.mdr_out = 1'b1; bus.ir_in = 1'b1; end
            S_T3: begin
                case (cls)
                    CL_RTYPE, CL_IMM: begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1; end
                    CL_LD, CL_ST:     begin bus.grb = 1'b1; bus.ba_out = 1'b1; bus.y_in = 1'b1; end
                    CL_BR:            begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.con_in = 1'b1; end
                    CL_JR:            begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.pc_in = 1'b1; end
`ifdef CU_MULDIV_EN
                    CL_MULDIV:        begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.y_in = 1'b1; end
                    CL_MFHL: begin
                        bus.hi_out = (opcode == OP_MFHI);
                        bus.lo_out = (opcode != OP_MFHI);
                        bus.gra    = 1'b1;
                        bus.r_in   = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CL_RTYPE:  begin bus.grc = 1'b1; bus.r_out = 1'b1; bus.alu_op = opcode; bus.z_in = 1'b1; end
                    CL_IMM:    begin bus.c_out = 1'b1; bus.alu_op = imm_alu_op(opcode); bus.z_in = 1'b1; end
                    CL_LD, CL_ST: begin bus.c_out = 1'b1; bus.alu_op = OP_ADD; bus.z_in = 1'b1; end
                    CL_BR:     begin bus.pc_out = 1'b1; bus.y_in = 1'b1; end
`ifdef CU_MULDIV_EN
                    CL_MULDIV: begin bus.grb = 1'b1; bus.r_out = 1'b1; bus.alu_op = opcode; bus.z_in = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CL_RTYPE, CL_IMM: begin bus.zlo_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
                    CL_LD, CL_ST:     begin bus.zlo_out = 1'b1; bus.mar_in = 1'b1; end
                    CL_BR:            begin bus.c_out = 1'b1; bus.alu_op = OP_ADD; bus.z_in = 1'b1; end
`ifdef CU_MULDIV_EN
                    CL_MULDIV:        begin bus.zlo_out = 1'b1; bus.lo_in = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    CL_LD: begin bus.mdr_read = 1'b1; bus.mdr_in = 1'b1; end
                    CL_ST: begin bus.gra = 1'b1; bus.r_out = 1'b1; bus.mdr_in = 1'b1; end
                    // The only input-to-output path: branch taken decision.
                    CL_BR: begin bus.zlo_out = 1'b1; bus.pc_in = bus.con_ff; end
`ifdef CU_MULDIV_EN
                    CL_MULDIV: begin bus.zhi_out = 1'b1; bus.hi_in = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    CL_LD: begin bus.mdr_out = 1'b1; bus.gra = 1'b1; bus.r_in = 1'b1; end
                    CL_ST: bus.mem_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit: a per-opcode step table built
// from the instruction behaviour predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_control_unit;

    localparam int LIMIT = 4;

    localparam int PC_OUT = 0,  PC_IN = 1,   INC_PC = 2,   MAR_IN = 3,   MDR_IN = 4;
    localparam int MDR_OUT = 5, MDR_READ = 6, MEM_WRITE = 7, IR_IN = 8,   Y_IN = 9;
    localparam int Z_IN = 10,   ZLO_OUT = 11, ZHI_OUT = 12, C_OUT = 13,  CON_IN = 14;
    localparam int GRA = 15,    GRB = 16,    GRC = 17,     R_IN = 18,    R_OUT = 19;
    localparam int BA_OUT = 20, HI_IN = 21,  LO_IN = 22,   HI_OUT = 23,  LO_OUT = 24;

`ifdef CU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    typedef struct packed {
        logic [24:0] s;
        logic [4:0]  alu;
        logic        run;
        logic        halted;
        logic [1:0]  fault;
    } exp_t;

    typedef struct {
        logic [24:0] s;
        logic [4:0]  alu;
        bit          wt;
        bit          pcc;
    } step_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    cu_if bus ();

    control_unit #(.WAIT_LIMIT(LIMIT)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t  sb[$];
    step_t prog[$];
    int    term;
    int    checks = 0;
    int    failures = 0;
    int    pushed = 0;

    function automatic logic [24:0] b(input int i);
        logic [24:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic void add_step(input logic [24:0] s, input logic [4:0] alu, input bit wt, input bit pcc);
        step_t st;
        st.s = s; st.alu = alu; st.wt = wt; st.pcc = pcc;
        prog.push_back(st);
    endfunction

    // Expected step list per instruction; term: 0 back to fetch, 1 halt, 2 illegal.
    function automatic void plan(input logic [4:0] op);
        prog.delete();
        term = 0;
        add_step(b(PC_OUT) | b(MAR_IN) | b(INC_PC), 5'd0, 0, 0);
        add_step(b(MDR_READ) | b(MDR_IN), 5'd0, 1, 0);
        add_step(b(MDR_OUT) | b(IR_IN), 5'd0, 0, 0);
        if (op <= 5'd7) begin
            add_step(b(GRB) | b(R_OUT) | b(Y_IN), 5'd0, 0, 0);
            add_step(b(GRC) | b(R_OUT) | b(Z_IN), op, 0, 0);
            add_step(b(ZLO_OUT) | b(GRA) | b(R_IN), 5'd0, 0, 0);
        end else if (op <= 5'd10) begin
            add_step(b(GRB) | b(R_OUT) | b(Y_IN), 5'd0, 0, 0);
            add_step(b(C_OUT) | b(Z_IN), (op == 5'd8) ? 5'd0 : (op == 5'd9) ? 5'd2 : 5'd3, 0, 0);
            add_step(b(ZLO_OUT) | b(GRA) | b(R_IN), 5'd0, 0, 0);
        end else if (op == 5'd11 || op == 5'd12) begin
            add_step(b(GRB) | b(BA_OUT) | b(Y_IN), 5'd0, 0, 0);
            add_step(b(C_OUT) | b(Z_IN), 5'd0, 0, 0);
            add_step(b(ZLO_OUT) | b(MAR_IN), 5'd0, 0, 0);
            if (op == 5'd11) begin
                add_step(b(MDR_READ) | b(MDR_IN), 5'd0, 1, 0);
                add_step(b(MDR_OUT) | b(GRA) | b(R_IN), 5'd0, 0, 0);
            end else begin
                add_step(b(GRA) | b(R_OUT) | b(MDR_IN), 5'd0, 0, 0);
                add_step(b(MEM_WRITE), 5'd0, 1, 0);
            end
        end else if (op == 5'd13) begin
            add_step(b(GRA) | b(R_OUT) | b(CON_IN), 5'd0, 0, 0);
            add_step(b(PC_OUT) | b(Y_IN), 5'd0, 0, 0);
            add_step(b(C_OUT) | b(Z_IN), 5'd0, 0, 0);
            add_step(b(ZLO_OUT), 5'd0, 0, 1);
        end else if (op == 5'd14) begin
            add_step(b(GRA) | b(R_OUT) | b(PC_IN), 5'd0, 0, 0);
        end else if (MULDIV && (op == 5'd15 || op == 5'd16)) begin
            add_step(b(GRA) | b(R_OUT) | b(Y_IN), 5'd0, 0, 0);
            add_step(b(GRB) | b(R_OUT) | b(Z_IN), op, 0, 0);
            add_step(b(ZLO_OUT) | b(LO_IN), 5'd0, 0, 0);
            add_step(b(ZHI_OUT) | b(HI_IN), 5'd0, 0, 0);
        end else if (MULDIV && (op == 5'd17 || op == 5'd18)) begin
            add_step(((op == 5'd17) ? b(HI_OUT) : b(LO_OUT)) | b(GRA) | b(R_IN), 5'd0, 0, 0);
        end else if (op == 5'd19) begin
            add_step('0, 5'd0, 0, 0);
        end else if (op == 5'd20) begin
            add_step('0, 5'd0, 0, 0);
            term = 1;
        end else begin
            add_step('0, 5'd0, 0, 0);
            term = 2;
        end
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.s = {bus.lo_out, bus.hi_out, bus.lo_in, bus.hi_in, bus.ba_out, bus.r_out, bus.r_in,
               bus.grc, bus.grb, bus.gra, bus.con_in, bus.c_out, bus.zhi_out, bus.zlo_out,
               bus.z_in, bus.y_in, bus.ir_in, bus.mem_write, bus.mdr_read, bus.mdr_out,
               bus.mdr_in, bus.mar_in, bus.inc_pc, bus.pc_in, bus.pc_out};
        a.alu = bus.alu_op;
        a.run = bus.run;
        a.halted = bus.halted;
        a.fault = bus.fault;
        return a;
    endfunction

    task automatic apply_stimulus(input exp_t e, input logic rdy, input logic cf,
                                  input logic [31:0] irv, input logic rst);
        @(posedge clk);
        #1;
        clr = rst;
        bus.mem_rdy = rdy;
        bus.con_ff = cf;
        bus.ir = irv;
        sb.push_back(e);
        pushed++;
    endtask

    task automatic check_output(input exp_t e, input exp_t a);
        checks++;
        if (a !== e) begin
            failures++;
            $display("[TB] FAIL outputs@%0t act s=%h alu=%h run=%b halted=%b fault=%b exp s=%h alu=%h run=%b halted=%b fault=%b",
                     $time, a.s, a.alu, a.run, a.halted, a.fault, e.s, e.alu, e.run, e.halted, e.fault);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) check_output(sb.pop_front(), sample());
    end

    task automatic do_reset();
        apply_stimulus('0, 1'($urandom), 1'($urandom), $urandom, 1'b1);
        apply_stimulus('0, 1'($urandom), 1'($urandom), $urandom, 1'b1);
        apply_stimulus('0, 1'($urandom), 1'($urandom), $urandom, 1'b0);
    endtask

    task automatic halt_check(input logic [1:0] f);
        exp_t e;
        e = '0;
        e.halted = 1'b1;
        e.fault = f;
        repeat (3) apply_stimulus(e, 1'($urandom), 1'($urandom), $urandom, 1'b0);
        do_reset();
    endtask

    // cf_mode: 0/1 force con_ff, 2 random. abort_at: cycle index to assert clr, -1 never.
    task automatic run_instr(input logic [4:0] op, input int st_a, input int st_b,
                             input int cf_mode, input int abort_at);
        logic [31:0] instr;
        int   cyc;
        int   low;
        bit   timed_out;
        logic cf;
        exp_t e;
        instr = {op, 27'($urandom)};
        plan(op);
        cyc = 0;
        for (int i = 0; i < prog.size(); i++) begin
            low = prog[i].wt ? ((i == 1) ? st_a : st_b) : 0;
            timed_out = 1'b0;
            if (low >= LIMIT) begin
                low = LIMIT;
                timed_out = 1'b1;
            end
            for (int k = 0; k <= low; k++) begin
                if (timed_out && k == low) begin
                    halt_check(2'b10);
                    return;
                end
                if (cyc == abort_at) begin
                    do_reset();
                    return;
                end
                cf = (cf_mode == 2) ? 1'($urandom) : cf_mode[0];
                e = '0;
                e.s = prog[i].s;
                if (prog[i].pcc) e.s[PC_IN] = cf;
                e.alu = prog[i].alu;
                e.run = 1'b1;
                apply_stimulus(e, prog[i].wt ? (k == low) : 1'($urandom), cf,
                               (i < 3) ? $urandom : instr, 1'b0);
                cyc++;
            end
        end
        if (term == 1) halt_check(2'b00);
        else if (term == 2) halt_check(2'b01);
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int op, sa, sbw, ab;
        bus.ir = '0;
        bus.con_ff = 1'b0;
        bus.mem_rdy = 1'b1;
        do_reset();
        run_instr(5'd0, 0, 0, 2, -1);
        run_instr(5'd11, 0, 3, 2, -1);
        run_instr(5'd13, 0, 0, 0, -1);
        run_instr(5'd13, 0, 0, 1, -1);
        run_instr(5'd15, 0, 0, 2, -1);
        run_instr(5'd31, 0, 0, 2, -1);
        run_instr(5'd0, 10, 0, 2, -1);
        run_instr(5'd12, 0, 0, 2, 7);
        run_instr(5'd14, 1, 0, 2, -1);
        run_instr(5'd19, 0, 0, 2, -1);
        run_instr(5'd20, 0, 0, 2, -1);
        for (int n = 0; n < 60; n++) begin
            op  = $urandom_range(0, 31);
            sa  = $urandom_range(0, 3);
            sbw = ($urandom_range(0, 15) == 0) ? LIMIT : $urandom_range(0, 3);
            ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            run_instr(5'(op), sa, sbw, 2, ab);
        end
        repeat (3) @(posedge clk);
        if (sb.size() != 0 || checks != pushed) begin
            failures++;
            $display("[TB] FAIL drain act=%0d checked exp=%0d pushed", checks, pushed);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
